// File: rtl/daq_usb_transmit.sv
// daq_usb_transmit: buffers the DAQ word stream in a FIFO, forwards it to the USB write port
// under back-pressure and answers AllDone with DataTransmitDone once the buffer has drained.
module daq_usb_transmit #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        ModuleStart,
  input  logic [15:0] SlaveDaqData,
  input  logic        SlaveDaqData_en,
  input  logic        AllDone,
  input  logic        UsbFifoFull,
  output logic [15:0] UsbData,
  output logic        UsbData_en,
  output logic        DataTransmitDone,
  output logic        Overflow,
  output logic [23:0] WordCount,
  output logic        Busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nextState;
  logic [15:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DEPTH_LOG2:0] occ;
  logic msPrev, fifoFull, fifoEmpty, wr, rd, startRun;
  // occupancy never exceeds DEPTH, so its MSB alone flags a full buffer
  assign fifoFull  = occ[DEPTH_LOG2];
  assign fifoEmpty = occ == '0;
  assign wr        = SlaveDaqData_en & ~fifoFull;
  assign rd        = ~fifoEmpty & ~UsbFifoFull;
  assign startRun  = state == IDLE && ModuleStart && !msPrev;
  always_ff @(posedge Clk)
    if (wr) mem[wrPtr] <= SlaveDaqData;
  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState        = state;
    nextState        = state == IDLE  ? (AllDone ? DRAIN : startRun ? RUN : IDLE) :
                       state == RUN   ? (AllDone ? DRAIN : RUN) :
                       state == DRAIN ? (fifoEmpty && !UsbData_en ? DONE : DRAIN) :
                                        (AllDone ? DONE : IDLE);
    DataTransmitDone = state == DONE;
    Busy             = state != IDLE;
  end
  always_ff @(posedge Clk or negedge reset_n)
    if (!reset_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      occ        <= '0;
      msPrev     <= 1'b0;
      UsbData    <= '0;
      UsbData_en <= 1'b0;
      Overflow   <= 1'b0;
      WordCount  <= '0;
    end else begin
      msPrev     <= ModuleStart;
      wrPtr      <= wrPtr + DEPTH_LOG2'(wr);
      rdPtr      <= rdPtr + DEPTH_LOG2'(rd);
      occ        <= occ + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(rd);
      UsbData_en <= rd;
      if (rd) UsbData <= mem[rdPtr];
      Overflow   <= (Overflow & ~startRun) | (SlaveDaqData_en & fifoFull);
      WordCount  <= startRun ? '0 : WordCount + 24'(UsbData_en && WordCount != 24'hFFFFFF);
    end
endmodule

// File: tb/tb_daq_usb_transmit.sv
// tb_daq_usb_transmit: table vectors, directed handshake/overflow/reset sequences and a
// randomized run checked against a queue-based reference of the buffer.
module tb_daq_usb_transmit;
  logic        Clk = 0, reset_n = 1, ModuleStart = 0, SlaveDaqData_en = 0, AllDone = 0, UsbFifoFull = 0;
  logic [15:0] SlaveDaqData = 0;
  logic [15:0] UsbData;
  logic        UsbData_en, DataTransmitDone, Overflow, Busy;
  logic [23:0] WordCount;
  int checks = 0, errors = 0;

  typedef struct {
    logic        en;
    logic [15:0] d;
    logic        full;
    logic        expEn;
    logic [15:0] expD;
  } vec_t;
  vec_t tbl[10];

  always #5 Clk = ~Clk;

  daq_usb_transmit #(.DEPTH_LOG2(9)) dut (
    .Clk(Clk), .reset_n(reset_n), .ModuleStart(ModuleStart), .SlaveDaqData(SlaveDaqData),
    .SlaveDaqData_en(SlaveDaqData_en), .AllDone(AllDone), .UsbFifoFull(UsbFifoFull),
    .UsbData(UsbData), .UsbData_en(UsbData_en), .DataTransmitDone(DataTransmitDone),
    .Overflow(Overflow), .WordCount(WordCount), .Busy(Busy)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int pulses, doneAt, occM, pops, stray;
  bit ovfM, doPop, e, f;
  logic [15:0] q[$];
  logic [15:0] d, expD;

  initial begin
    tbl[0] = '{1'b1, 16'hAABB, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 16'hFF45, 1'b0, 1'b1, 16'hAABB};
    tbl[2] = '{1'b1, 16'hCCDD, 1'b0, 1'b1, 16'hFF45};
    tbl[3] = '{1'b1, 16'h0003, 1'b0, 1'b1, 16'hCCDD};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003};
    tbl[6] = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0003};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234};
    tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234};

    #1 reset_n = 0;
    cyc(); cyc();
    chk("rst_data", UsbData, 0);
    chk("rst_en", UsbData_en, 0);
    chk("rst_done", DataTransmitDone, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_wc", WordCount, 0);
    chk("rst_busy", Busy, 0);
    reset_n = 1;
    cyc();
    chk("idle_busy", Busy, 0);
    ModuleStart = 1;
    cyc();
    chk("run_busy", Busy, 1);

    for (int i = 0; i < 10; i++) begin
      SlaveDaqData_en = tbl[i].en; SlaveDaqData = tbl[i].d; UsbFifoFull = tbl[i].full;
      cyc();
      chk($sformatf("tbl%0d_en", i), UsbData_en, tbl[i].expEn);
      chk($sformatf("tbl%0d_data", i), UsbData, tbl[i].expD);
    end
    chk("basic_wc", WordCount, 5);

    UsbFifoFull = 1;
    for (int i = 0; i < 10; i++) begin
      SlaveDaqData_en = 1; SlaveDaqData = 16'h0100 + 16'(i);
      cyc();
      chk("bp_hold_en", UsbData_en, 0);
    end
    SlaveDaqData_en = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_hold_en", UsbData_en, 0);
    end
    UsbFifoFull = 0;
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_word%0d", i), {UsbData_en, UsbData}, {1'b1, 16'h0100 + 16'(i)});
      cyc();
    end
    chk("bp_end_en", UsbData_en, 0);
    chk("bp_ovf", Overflow, 0);
    chk("bp_wc", WordCount, 15);

    UsbFifoFull = 1;
    for (int i = 0; i < 3; i++) begin
      SlaveDaqData_en = 1; SlaveDaqData = 16'h0200 + 16'(i);
      cyc();
    end
    SlaveDaqData_en = 0; AllDone = 1; UsbFifoFull = 0;
    pulses = 0; doneAt = -1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (DataTransmitDone) begin doneAt = i; break; end
      pulses += int'(UsbData_en);
    end
    chk("drain_pulses", pulses, 3);
    chk("drain_done_at", doneAt, 4);
    SlaveDaqData_en = 1; SlaveDaqData = 16'hBEEF;
    cyc();
    SlaveDaqData_en = 0;
    chk("done_hold", DataTransmitDone, 1);
    cyc();
    chk("done_strobe", {UsbData_en, UsbData}, {1'b1, 16'hBEEF});
    chk("done_hold2", DataTransmitDone, 1);
    AllDone = 0;
    cyc();
    chk("done_fall", DataTransmitDone, 0);
    chk("done_idle", Busy, 0);
    chk("done_wc", WordCount, 19);

    ModuleStart = 0; cyc();
    ModuleStart = 1; cyc();
    chk("rs1_busy", Busy, 1);
    chk("rs1_wc", WordCount, 0);
    UsbFifoFull = 1;
    for (int i = 0; i < 514; i++) begin
      SlaveDaqData_en = 1; SlaveDaqData = 16'(i);
      cyc();
    end
    SlaveDaqData_en = 0;
    chk("ovf_set", Overflow, 1);
    UsbFifoFull = 0;
    cyc();
    for (int i = 0; i < 512; i++) begin
      chk("ovf_word", {UsbData_en, UsbData}, {1'b1, 16'(i)});
      cyc();
    end
    chk("ovf_no_extra", UsbData_en, 0);
    chk("ovf_wc", WordCount, 512);

    AllDone = 1;
    cyc();
    chk("qd_drain", {Busy, DataTransmitDone}, 2'b10);
    cyc();
    chk("qd_done", DataTransmitDone, 1);
    AllDone = 0;
    cyc();
    chk("qd_idle", {Busy, DataTransmitDone}, 2'b00);
    chk("qd_ovf_kept", Overflow, 1);
    ModuleStart = 0; cyc();
    ModuleStart = 1; cyc();
    chk("rs2_ovf", Overflow, 0);
    chk("rs2_wc", WordCount, 0);

    for (int i = 0; i < 2; i++) begin
      SlaveDaqData_en = 1; SlaveDaqData = 16'h0300 + 16'(i);
      cyc();
    end
    SlaveDaqData_en = 0;
    cyc(); cyc(); cyc();
    chk("mr_wc", WordCount, 2);
    UsbFifoFull = 1;
    for (int i = 0; i < 5; i++) begin
      SlaveDaqData_en = 1; SlaveDaqData = 16'h0400 + 16'(i);
      cyc();
    end
    SlaveDaqData_en = 0; UsbFifoFull = 0;
    cyc();
    chk("mr_flowing", UsbData_en, 1);
    #2 reset_n = 0; ModuleStart = 0;
    #1;
    chk("mr_en", UsbData_en, 0);
    chk("mr_data", UsbData, 0);
    chk("mr_done", DataTransmitDone, 0);
    chk("mr_wc0", WordCount, 0);
    chk("mr_busy", Busy, 0);
    cyc(); cyc();
    reset_n = 1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      stray += int'(UsbData_en);
    end
    chk("mr_stale", stray, 0);

    ModuleStart = 1;
    cyc();
    chk("rnd_start_wc", WordCount, 0);
    occM = 0; pops = 0; ovfM = 0; q.delete();
    for (int c = 0; c < 2400; c++) begin
      e = c < 700 ? ($urandom_range(9, 0) != 0) : c < 1800 ? 1'($urandom_range(1, 0)) : 1'b0;
      f = c < 700 ? ($urandom_range(9, 0) != 0) : c < 1800 ? ($urandom_range(4, 0) == 0) : 1'b0;
      d = 16'($urandom);
      SlaveDaqData_en = e; SlaveDaqData = d; UsbFifoFull = f;
      doPop = occM > 0 && !f;
      if (doPop) begin expD = q.pop_front(); pops++; end
      if (e && occM < 512) q.push_back(d);
      else if (e) ovfM = 1;
      occM = q.size();
      cyc();
      chk("rnd_en", UsbData_en, doPop);
      if (doPop) chk("rnd_data", UsbData, expD);
    end
    SlaveDaqData_en = 0;
    cyc();
    chk("rnd_wc", WordCount, pops);
    chk("rnd_ovf", Overflow, ovfM);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
